// File: rtl/timekeeper_pkg.sv
// Shared types and constants for the adjustable timekeeper: FSM states, field indices and BCD helpers.
package timekeeper_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        ADJUST = 2'd2
    } state_t;

    localparam int unsigned FIELD_SS = 0;
    localparam int unsigned FIELD_MM = 1;
    localparam int unsigned FIELD_HH = 2;

    localparam int unsigned SEXAGESIMAL_MAX = 59;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t ones;
    } bcd_pair_t;

    function automatic bcd_pair_t to_bcd(input int unsigned v);
        bcd_pair_t r;
        r.tens = 4'((v / 10) % 10);
        r.ones = 4'(v % 10);
        return r;
    endfunction

    // Largest value a field may hold; seconds and minutes are base-60, hours follow hour_max.
    function automatic bcd_pair_t field_max(input int unsigned field, input int unsigned hour_max);
        if (field == FIELD_SS || field == FIELD_MM) begin
            return to_bcd(SEXAGESIMAL_MAX);
        end
        if (field == FIELD_HH) begin
            return to_bcd(hour_max - 1);
        end
        return to_bcd(0);
    endfunction

endpackage

// File: rtl/bcd_field_counter.sv
// One 2-digit BCD modulo counter (0..max_value) stepping up or down; wrap_c flags a pending wrap.
module bcd_field_counter
    import timekeeper_pkg::*;
(
    input  logic      clk4hz,
    input  logic      reset,
    input  logic      step,
    input  logic      dir,
    input  bcd_pair_t max_value,
    output bcd_pair_t value,
    output logic      wrap_c
);

    bcd_pair_t value_next;

    always_comb begin
        value_next = value;
        wrap_c     = dir ? (value == '0) : (value == max_value);
        if (dir) begin
            if (wrap_c) begin
                value_next = max_value;
            end else if (value.ones == 4'd0) begin
                value_next.tens = 4'(value.tens - 4'd1);
                value_next.ones = 4'd9;
            end else begin
                value_next.ones = 4'(value.ones - 4'd1);
            end
        end else begin
            if (wrap_c) begin
                value_next = '0;
            end else if (value.ones == 4'd9) begin
                value_next.tens = 4'(value.tens + 4'd1);
                value_next.ones = 4'd0;
            end else begin
                value_next.ones = 4'(value.ones + 4'd1);
            end
        end
    end

    always_ff @(posedge clk4hz) begin
        if (reset) begin
            value <= '0;
        end else if (step) begin
            value <= value_next;
        end
    end

endmodule

// File: rtl/adjustable_timekeeper.sv
// Time-of-day/stopwatch core: BCD ss/mm[/hh] fields with run, pause and per-field adjust modes.
// Define TIMEKEEPER_BLINK_EN to build the blink phase that drives blank_mask during adjust.
module adjustable_timekeeper
    import timekeeper_pkg::*;
#(
    parameter int unsigned NUM_FIELDS    = 2,
    parameter int unsigned HOUR_MAX      = 24,
    parameter int unsigned TICKS_PER_SEC = 4,
    parameter int unsigned ADJ_TICKS     = 2
) (
    input  logic                    clk4hz,
    input  logic                    reset,
    input  logic                    pause_btn,
    input  logic                    adjust,
    input  logic [1:0]              field_sel,
    input  logic                    dir,
    output logic [8*NUM_FIELDS-1:0] digits,
    output logic [2*NUM_FIELDS-1:0] blank_mask,
    output logic                    paused,
    output logic                    rollover
);

    localparam int unsigned PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned ADJ_W = (ADJ_TICKS > 1) ? $clog2(ADJ_TICKS) : 1;

    state_t               state, state_next;
    logic [PRE_W-1:0]     prescaler, prescaler_next;
    logic [ADJ_W-1:0]     adj_cnt, adj_cnt_next;
    logic                 pause_prev;
    logic                 pause_edge_c;
    logic                 entering_c;
    logic                 run_step_c;
    logic                 adj_step_c;
    logic [NUM_FIELDS-1:0] field_step_c;
    logic [NUM_FIELDS-1:0] field_wrap_c;

    assign pause_edge_c = pause_btn & ~pause_prev;

    // Mode selection and step strobes; entering ADJUST takes priority over any counting that edge.
    always_comb begin
        state_next     = state;
        prescaler_next = prescaler;
        adj_cnt_next   = adj_cnt;
        run_step_c     = 1'b0;
        adj_step_c     = 1'b0;

        if (adjust) begin
            state_next = ADJUST;
        end else begin
            unique case (state)
                RUN:     state_next = pause_edge_c ? PAUSED : RUN;
                PAUSED:  state_next = pause_edge_c ? RUN : PAUSED;
                default: state_next = RUN;
            endcase
        end

        entering_c = (state_next == ADJUST) && (state != ADJUST);

        if (entering_c) begin
            prescaler_next = '0;
            adj_cnt_next   = '0;
        end else if (state == ADJUST && state_next == ADJUST) begin
            if (adj_cnt == ADJ_W'(ADJ_TICKS - 1)) begin
                adj_step_c   = 1'b1;
                adj_cnt_next = '0;
            end else begin
                adj_cnt_next = ADJ_W'(adj_cnt + 1'b1);
            end
        end else if (state == RUN && state_next == RUN) begin
            if (prescaler == PRE_W'(TICKS_PER_SEC - 1)) begin
                run_step_c     = 1'b1;
                prescaler_next = '0;
            end else begin
                prescaler_next = PRE_W'(prescaler + 1'b1);
            end
        end
    end

    always_ff @(posedge clk4hz) begin
        if (reset) begin
            state      <= RUN;
            prescaler  <= '0;
            adj_cnt    <= '0;
            pause_prev <= 1'b0;
            paused     <= 1'b0;
            rollover   <= 1'b0;
        end else begin
            state      <= state_next;
            prescaler  <= prescaler_next;
            adj_cnt    <= adj_cnt_next;
            pause_prev <= pause_btn;
            paused     <= (state_next == PAUSED);
            rollover   <= run_step_c & (&field_wrap_c);
        end
    end

    // Run steps ripple upward through wrapping fields; adjust steps hit only the selected field.
    for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_field
        localparam bcd_pair_t FMAX = field_max(f, HOUR_MAX);
        logic carry_c;

        if (f == FIELD_SS) begin : g_lsb
            assign carry_c = run_step_c;
        end else begin : g_upper
            assign carry_c = run_step_c & (&field_wrap_c[f-1:0]);
        end

        assign field_step_c[f] = carry_c | (adj_step_c && (field_sel == 2'(f)));

        bcd_field_counter u_field (
            .clk4hz    (clk4hz),
            .reset     (reset),
            .step      (field_step_c[f]),
            .dir       (dir),
            .max_value (FMAX),
            .value     (digits[8*f +: 8]),
            .wrap_c    (field_wrap_c[f])
        );
    end

`ifdef TIMEKEEPER_BLINK_EN
    logic                    blink_phase, blink_phase_next;
    logic [2*NUM_FIELDS-1:0] blank_next;

    always_comb begin
        blink_phase_next = 1'b0;
        blank_next       = '0;
        if (state_next == ADJUST) begin
            blink_phase_next = entering_c ? 1'b0 : ~blink_phase;
            for (int f = 0; f < NUM_FIELDS; f++) begin
                if (field_sel == 2'(f)) begin
                    blank_next[2*f +: 2] = {2{blink_phase_next}};
                end
            end
        end
    end

    always_ff @(posedge clk4hz) begin
        if (reset) begin
            blink_phase <= 1'b0;
            blank_mask  <= '0;
        end else begin
            blink_phase <= blink_phase_next;
            blank_mask  <= blank_next;
        end
    end
`else
    assign blank_mask = '0;
`endif

endmodule

// File: tb/tb_adjustable_timekeeper.sv
// Self-checking bench for adjustable_timekeeper (hh:mm:ss build) against a seconds-based reference model.
module tb_adjustable_timekeeper;

    localparam int NF  = 3;
    localparam int HM  = 24;
    localparam int TPS = 4;
    localparam int AT  = 2;

    localparam int M_RUN   = 0;
    localparam int M_PAUSE = 1;
    localparam int M_ADJ   = 2;

    logic            clk4hz = 1'b0;
    logic            reset;
    logic            pause_btn;
    logic            adjust;
    logic [1:0]      field_sel;
    logic            dir;
    logic [8*NF-1:0] digits;
    logic [2*NF-1:0] blank_mask;
    logic            paused;
    logic            rollover;

    int total = 0;
    int bad   = 0;

    adjustable_timekeeper #(
        .NUM_FIELDS    (NF),
        .HOUR_MAX      (HM),
        .TICKS_PER_SEC (TPS),
        .ADJ_TICKS     (AT)
    ) dut (
        .clk4hz     (clk4hz),
        .reset      (reset),
        .pause_btn  (pause_btn),
        .adjust     (adjust),
        .field_sel  (field_sel),
        .dir        (dir),
        .digits     (digits),
        .blank_mask (blank_mask),
        .paused     (paused),
        .rollover   (rollover)
    );

    always #5 clk4hz = ~clk4hz;

    // Reference model state: fields as plain integers, mode, tick counters.
    int        m_mode;
    int        m_pre;
    int        m_adj;
    int        m_fields[3];
    bit        m_phase;
    bit        m_prev;
    bit        m_roll;
    bit        m_valid = 1'b0;
    logic [5:0] m_blank;

    function automatic int modulus(input int i);
        return (i == 2) ? HM : 60;
    endfunction

    function automatic logic [7:0] bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [23:0] exp_digits();
        return {bcd8(m_fields[2]), bcd8(m_fields[1]), bcd8(m_fields[0])};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk4hz) begin : model
        int  t;
        int  span;
        bit  pe;
        span = 3600 * HM;
        if (reset) begin
            m_mode   = M_RUN;
            m_pre    = 0;
            m_adj    = 0;
            m_phase  = 1'b0;
            m_prev   = 1'b0;
            m_roll   = 1'b0;
            m_fields = '{0, 0, 0};
            m_valid  = 1'b1;
        end else begin
            pe     = pause_btn && !m_prev;
            m_prev = pause_btn;
            m_roll = 1'b0;
            if (adjust) begin
                if (m_mode != M_ADJ) begin
                    m_mode  = M_ADJ;
                    m_pre   = 0;
                    m_adj   = 0;
                    m_phase = 1'b0;
                end else begin
                    m_phase = !m_phase;
                    if (m_adj == AT - 1) begin
                        m_adj = 0;
                        if (int'(field_sel) < NF)
                            m_fields[field_sel] = (m_fields[field_sel] +
                                (dir ? modulus(int'(field_sel)) - 1 : 1)) % modulus(int'(field_sel));
                    end else begin
                        m_adj++;
                    end
                end
            end else if (m_mode == M_ADJ) begin
                m_mode = M_RUN;
            end else if (m_mode == M_PAUSE) begin
                if (pe) m_mode = M_RUN;
            end else if (pe) begin
                m_mode = M_PAUSE;
            end else if (m_pre == TPS - 1) begin
                m_pre = 0;
                t = m_fields[0] + 60 * m_fields[1] + 3600 * m_fields[2];
                if (!dir) begin
                    m_roll = (t == span - 1);
                    t = (t + 1) % span;
                end else begin
                    m_roll = (t == 0);
                    t = (t + span - 1) % span;
                end
                m_fields[0] = t % 60;
                m_fields[1] = (t / 60) % 60;
                m_fields[2] = t / 3600;
            end else begin
                m_pre++;
            end
        end
        m_blank = '0;
`ifdef TIMEKEEPER_BLINK_EN
        if (m_mode == M_ADJ && int'(field_sel) < NF && m_phase)
            m_blank = 6'(3 << (2 * int'(field_sel)));
`endif
    end

    always @(negedge clk4hz) begin
        if (m_valid) begin
            chk("digits", 32'(digits), 32'(exp_digits()));
            chk("paused", 32'(paused), 32'(m_mode == M_PAUSE));
            chk("rollover", 32'(rollover), 32'(m_roll));
            chk("blank_mask", 32'(blank_mask), 32'(m_blank));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk4hz);
    endtask

    initial begin
        logic [5:0] blink_exp;
        reset     = 1'b1;
        pause_btn = 1'b0;
        adjust    = 1'b0;
        field_sel = 2'd0;
        dir       = 1'b0;
        cycles(2);
        chk("reset_digits", 32'(digits), 32'h0);
        chk("reset_paused", 32'(paused), 32'h0);
        chk("reset_blank", 32'(blank_mask), 32'h0);
        reset = 1'b0;

        cycles(4);
        chk("first_second", 32'(digits), 32'h000001);
        cycles(236);
        chk("one_minute", 32'(digits), 32'h000100);

        // Preload 23:59:59 by adjusting each field downward.
        adjust = 1'b1; field_sel = 2'd3; cycles(1);
        field_sel = 2'd0; dir = 1'b1; cycles(2);
        field_sel = 2'd1; cycles(4);
        field_sel = 2'd2; cycles(2);
        chk("preload", 32'(digits), 32'h235959);
        adjust = 1'b0; dir = 1'b0; cycles(1);
        cycles(4);
        chk("up_wrap_digits", 32'(digits), 32'h000000);
        chk("up_wrap_rollover", 32'(rollover), 32'h1);

        dir = 1'b1;
        cycles(4);
        chk("down_wrap_digits", 32'(digits), 32'h235959);
        chk("down_wrap_rollover", 32'(rollover), 32'h1);
        cycles(4);
        chk("down_step", 32'(digits), 32'h235958);
        chk("down_no_rollover", 32'(rollover), 32'h0);

        adjust = 1'b1; field_sel = 2'd1; dir = 1'b0;
        cycles(7);
        chk("adjust_minutes", 32'(digits), 32'h230258);
        chk("blink_phase_low", 32'(blank_mask), 32'h0);
        cycles(1);
`ifdef TIMEKEEPER_BLINK_EN
        blink_exp = 6'b001100;
`else
        blink_exp = 6'b000000;
`endif
        chk("blink_phase_high", 32'(blank_mask), 32'(blink_exp));

        adjust = 1'b0; cycles(1);
        cycles(2);
        pause_btn = 1'b1; cycles(1);
        chk("pause_set", 32'(paused), 32'h1);
        cycles(20);
        chk("pause_held", 32'(paused), 32'h1);
        chk("pause_frozen", 32'(digits), 32'h230258);
        pause_btn = 1'b0; cycles(1);
        pause_btn = 1'b1; cycles(1);
        chk("resume", 32'(paused), 32'h0);
        cycles(2);
        chk("resume_prescaler", 32'(digits), 32'h230259);

        pause_btn = 1'b0;
        adjust = 1'b1; field_sel = 2'd0; cycles(3);
        reset = 1'b1; cycles(1);
        chk("reset_adj_digits", 32'(digits), 32'h0);
        chk("reset_adj_paused", 32'(paused), 32'h0);
        chk("reset_adj_blank", 32'(blank_mask), 32'h0);
        reset = 1'b0; adjust = 1'b0; cycles(1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) adjust = ~adjust;
            if ($urandom_range(0, 3) == 0) pause_btn = ~pause_btn;
            if ($urandom_range(0, 7) == 0) field_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) dir = ~dir;
            reset = ($urandom_range(0, 499) == 0);
            cycles(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
